layer_loader: RTL

Sequencing controller that fills a layer's per-node parameter shift registers over the shared n-bit parameter bus. On a start pulse it accepts sl·(sx+2) words from a valid/ready source stream and drives each word onto the bus. It asserts exactly one node write-enable per word, walking node by node. It sits between the parameter source (ROM reader or host stream) and one layer instance, and signals completion so the network sequencer can begin inference.

---
 rtl/layer_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/layer_loader.sv
// rtl/layer_loader.sv - streams sl*(sx+2) parameter words onto the layer bus, one node write-enable per word
module layer_loader #(
    parameter int sx = 2,
    parameter int sl = 3,
    parameter int n  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [n-1:0]  src_data,
    input  logic          src_valid,
    output logic          src_ready,
    output logic [n-1:0]  bus,
    output logic          bus_oe,
    output logic [sl-1:0] we,
    output logic          busy,
    output logic          done
);

    localparam int w  = sx + 2;
    // Counter widths are kept at least one bit so a single-node layer still elaborates.
    localparam int nw = (sl > 1) ? $clog2(sl) : 1;
    localparam int ww = (w > 1) ? $clog2(w) : 1;
    localparam logic [nw-1:0] node_last = nw'(sl - 1);
    localparam logic [ww-1:0] word_last = ww'(w - 1);

    typedef enum logic [1:0] {IDLE, LOAD, LAST, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [nw-1:0]  node_cnt;
    logic [ww-1:0]  word_cnt;
    logic           hs;
    logic [sl-1:0]  one_hot;

    // State register; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the state-derived handshake and status outputs.
    always_comb begin
        state_nxt = state;
        src_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        hs        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                src_ready = 1'b1;
                busy      = 1'b1;
                if (src_valid) begin
                    hs = 1'b1;
                    if (node_cnt == node_last && word_cnt == word_last) begin
                        state_nxt = LAST;
                    end
                end
            end
            LAST: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Node select: node k drives bit sl-1-k, so node 0 is the MSB.
    always_comb begin
        one_hot = '0;
        for (int i = 0; i < sl; i++) begin
            if (node_cnt == nw'(sl - 1 - i)) begin
                one_hot[i] = 1'b1;
            end
        end
    end

    // Word/node position within the image; cleared on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            node_cnt <= '0;
            word_cnt <= '0;
        end else if (state == IDLE && start) begin
            node_cnt <= '0;
            word_cnt <= '0;
        end else if (hs) begin
            if (word_cnt == word_last) begin
                word_cnt <= '0;
                if (node_cnt != node_last) begin
                    node_cnt <= node_cnt + 1'b1;
                end
            end else begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    // Registered bus stage: one write pulse per accepted word; bus holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus    <= '0;
            bus_oe <= 1'b0;
            we     <= '0;
        end else begin
            bus_oe <= hs;
            we     <= hs ? one_hot : '0;
            if (hs) begin
                bus <= src_data;
            end
        end
    end

endmodule
